avst_packet_mux: RTL

//  N-input Avalon-ST packet multiplexer; generalises the fixed 2-input UDP/ARP mux ahead of the TSE transmit port.

---
 rtl/avst_packet_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/avst_packet_mux.sv
// N-input Avalon-ST packet multiplexer: whole-packet round-robin arbitration, registered output, orphan discard.
// Build option: define AVST_MUX_PRIO_EN for fixed priority (input 0 highest) instead of round-robin.
module avst_packet_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  localparam int SEL_WIDTH  = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  avsi_data,
  input  logic [NUM_INPUTS-1:0]             avsi_valid,
  input  logic [NUM_INPUTS-1:0]             avsi_sop,
  input  logic [NUM_INPUTS-1:0]             avsi_eop,
  input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] avsi_empty,
  output logic [NUM_INPUTS-1:0]             avsi_ready,
  output logic [DATA_WIDTH-1:0]             avso_data,
  output logic                              avso_valid,
  output logic                              avso_sop,
  output logic                              avso_eop,
  output logic [EMPTY_WIDTH-1:0]            avso_empty,
  output logic [SEL_WIDTH-1:0]              avso_channel,
  input  logic                              avso_ready,
  output logic [15:0]                       err_orphan_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic [SEL_WIDTH-1:0]   grant, grant_nxt;
  logic [SEL_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_INPUTS-1:0]  req;
  logic [NUM_INPUTS-1:0]  orphan;
  logic                   ob_free;
  logic                   in_xfer;
  logic [SEL_WIDTH-1:0]   pick;
  logic                   pick_vld;
  logic [SEL_WIDTH:0]     idx_ext;
  logic [SEL_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid;
  logic                   sel_sop;
  logic                   sel_eop;
  logic [EMPTY_WIDTH-1:0] sel_empty;
  logic [16:0]            orph_sum;
  logic [15:0]            orph_cnt_nxt;

  assign ob_free = !avso_valid || avso_ready;
  assign req     = avsi_valid & avsi_sop;

  // Cyclic search from rr_ptr; with the priority build rr_ptr never leaves 0,
  // so the same search degenerates to lowest-index-wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx_ext  = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx_ext = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
      if (idx_ext >= (SEL_WIDTH+1)'(NUM_INPUTS))
        idx_ext = idx_ext - (SEL_WIDTH+1)'(NUM_INPUTS);
      idx = idx_ext[SEL_WIDTH-1:0];
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (grant == SEL_WIDTH'(k)) begin
        sel_data  = avsi_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = avsi_valid[k];
        sel_sop   = avsi_sop[k];
        sel_eop   = avsi_eop[k];
        sel_empty = avsi_empty[k*EMPTY_WIDTH +: EMPTY_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    avsi_ready = '0;
    orphan     = '0;
    in_xfer    = 1'b0;
    unique case (state)
      IDLE: begin
        orphan     = avsi_valid & ~avsi_sop;
        avsi_ready = orphan;
        if (pick_vld) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        avsi_ready[grant] = ob_free;
        in_xfer           = sel_valid && ob_free;
        if (in_xfer && sel_eop) begin
          state_nxt = IDLE;
`ifndef AVST_MUX_PRIO_EN
          rr_ptr_nxt = (grant == SEL_WIDTH'(NUM_INPUTS-1)) ? '0 : grant + 1'b1;
`endif
        end
      end
    endcase
    if (!reset_n)
      avsi_ready = '0;
  end

  // Several inputs may discard an orphan in the same cycle; each beat counts.
  always_comb begin
    orph_sum = {1'b0, err_orphan_cnt};
    for (int unsigned k = 0; k < NUM_INPUTS; k++)
      orph_sum = orph_sum + 17'(orphan[k]);
    orph_cnt_nxt = orph_sum[16] ? 16'hFFFF : orph_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      err_orphan_cnt <= '0;
      avso_data      <= '0;
      avso_valid     <= 1'b0;
      avso_sop       <= 1'b0;
      avso_eop       <= 1'b0;
      avso_empty     <= '0;
      avso_channel   <= '0;
    end else begin
      state          <= state_nxt;
      grant          <= grant_nxt;
      rr_ptr         <= rr_ptr_nxt;
      err_orphan_cnt <= orph_cnt_nxt;
      if (ob_free) begin
        if (in_xfer) begin
          avso_data    <= sel_data;
          avso_sop     <= sel_sop;
          avso_eop     <= sel_eop;
          avso_empty   <= sel_empty;
          avso_channel <= grant;
          avso_valid   <= 1'b1;
        end else begin
          avso_valid   <= 1'b0;
        end
      end
    end
  end

endmodule
